// File: rtl/eth_mii_rx.sv
`default_nettype none
// ============================================================================
//  Module      : eth_mii_rx
//  Description : Receive-side Ethernet MAC stage working on the raw MII
//                nibble stream. Strips preamble/SFD, assembles bytes
//                (low nibble first) and filters on destination MAC. It
//                captures the source MAC and length/type, checks the CRC32
//                residue, and emits the payload with the FCS removed,
//                followed by a good/bad verdict.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    mii_rx_clk   in   1   receive clock (25 MHz), the only clock
//    rst          in   1   synchronous active-high reset
//    mii_rx_dv    in   1   PHY receive data valid
//    mii_rx_er    in   1   PHY receive error
//    mii_rx_da    in   4   PHY receive nibble
//    rx_sof       out  1   pulse with the first payload byte of a frame
//    rx_byte_vld  out  1   rx_byte valid this cycle
//    rx_byte      out  8   payload byte (FCS never emitted)
//    rx_eof       out  1   pulse at frame end
//    rx_good      out  1   with rx_eof: frame passed every check
//    rx_bad       out  1   with rx_eof: frame failed a check
//    rx_len       out  11  payload bytes emitted, valid with rx_eof
//    rx_src_mac   out  48  source MAC of the last accepted frame
//    rx_len_type  out  16  length/type of the last accepted frame
//    err_cnt      out  16  saturating count of rejected frames
// ============================================================================
module eth_mii_rx #(
    parameter logic [47:0] LOCAL_MAC    = 48'h00_0a_35_01_fe_c0,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter int          MAX_FRAME    = 1518
) (
    input  logic        mii_rx_clk,
    input  logic        rst,
    input  logic        mii_rx_dv,
    input  logic        mii_rx_er,
    input  logic [3:0]  mii_rx_da,
    output logic        rx_sof,
    output logic        rx_byte_vld,
    output logic [7:0]  rx_byte,
    output logic        rx_eof,
    output logic        rx_good,
    output logic        rx_bad,
    output logic [10:0] rx_len,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_len_type,
    output logic [15:0] err_cnt
);

    localparam logic [31:0] c_POLY    = 32'hEDB88320;
    localparam logic [31:0] c_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] c_MAX_CNT = 11'(MAX_FRAME + 1);
    localparam logic [10:0] c_MIN_LEN = 11'd64;
    localparam logic [4:0]  c_DST_END = 5'd11;  // last nibble of destination
    localparam logic [4:0]  c_HDR_END = 5'd27;  // last nibble of length/type

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HDR      = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_DROP     = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic             armed_q,     armed_d;      // dv=0 seen since reset
    logic             pre_seen_q,  pre_seen_d;   // at least one 0x5 counted
    logic [4:0]       nib_cnt_q,   nib_cnt_d;    // header nibble index
    logic             phase_q,     phase_d;      // 1: next nibble is high half
    logic [3:0]       lo_nib_q,    lo_nib_d;
    logic [63:0]      hdr_q,       hdr_d;        // last 8 header bytes
    logic [10:0]      byte_cnt_q,  byte_cnt_d;   // bytes since SFD
    logic [31:0]      crc_q,       crc_d;
    logic             er_flag_q,   er_flag_d;
    logic [3:0][7:0]  dl_q,        dl_d;         // FCS-stripping delay line
    logic [2:0]       dl_cnt_q,    dl_cnt_d;
    logic [10:0]      len_cnt_q,   len_cnt_d;    // payload bytes emitted

    logic             sof_q,       sof_d;
    logic             vld_q,       vld_d;
    logic [7:0]       byte_q,      byte_d;
    logic             eof_q,       eof_d;
    logic             good_q,      good_d;
    logic             bad_q,       bad_d;
    logic [10:0]      len_q,       len_d;
    logic [47:0]      src_q,       src_d;
    logic [15:0]      type_q,      type_d;
    logic [15:0]      err_q,       err_d;

    logic             err_inc;
    logic             frame_bad;
    logic [7:0]       nib_byte;
    logic [47:0]      dst_addr;
    logic             dst_ok;
    logic [31:0]      crc_next;

    // Reflected CRC32, four input bits per call (LSB of the nibble first).
    function automatic logic [31:0] crc_nibble(input logic [31:0] crc,
                                               input logic [3:0]  nib);
        logic [31:0] c;
        c = crc ^ {28'h0, nib};
        for (int k = 0; k < 4; k++) begin
            c = c[0] ? ((c >> 1) ^ c_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // The byte completed this cycle, meaningful only when phase_q=1.
    assign nib_byte = {mii_rx_da, lo_nib_q};
    assign crc_next = crc_nibble(crc_q, mii_rx_da);
    // At the last destination nibble hdr_q holds the first five bytes.
    assign dst_addr = {hdr_q[39:0], nib_byte};
    assign dst_ok   = (dst_addr == LOCAL_MAC) ||
                      (ACCEPT_BCAST && (dst_addr == 48'hFFFF_FFFF_FFFF));
    assign frame_bad = (crc_q != c_RESIDUE) || phase_q || er_flag_q ||
                       (byte_cnt_q < c_MIN_LEN);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | ~mii_rx_dv;
        pre_seen_d = pre_seen_q;
        nib_cnt_d  = nib_cnt_q;
        phase_d    = phase_q;
        lo_nib_d   = lo_nib_q;
        hdr_d      = hdr_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        er_flag_d  = er_flag_q;
        dl_d       = dl_q;
        dl_cnt_d   = dl_cnt_q;
        len_cnt_d  = len_cnt_q;
        sof_d      = 1'b0;
        vld_d      = 1'b0;
        byte_d     = byte_q;
        eof_d      = 1'b0;
        good_d     = 1'b0;
        bad_d      = 1'b0;
        len_d      = len_q;
        src_d      = src_q;
        type_d     = type_q;
        err_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // armed_q holds off a frame already in flight at reset release.
                if (mii_rx_dv && armed_q) begin
                    state_d    = S_PREAMBLE;
                    pre_seen_d = 1'b0;
                end
            end

            S_PREAMBLE: begin
                if (!mii_rx_dv) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end else if (mii_rx_da == 4'h5) begin
                    pre_seen_d = 1'b1;
                end else if ((mii_rx_da == 4'hD) && pre_seen_q) begin
                    state_d    = S_HDR;
                    crc_d      = 32'hFFFF_FFFF;
                    nib_cnt_d  = 5'd0;
                    phase_d    = 1'b0;
                    byte_cnt_d = 11'd0;
                    er_flag_d  = 1'b0;
                    dl_cnt_d   = 3'd0;
                    len_cnt_d  = 11'd0;
                end else begin
                    state_d = S_DROP;
                    err_inc = 1'b1;
                end
            end

            S_HDR: begin
                if (!mii_rx_dv || mii_rx_er) begin
                    // With dv already low there is nothing left to skip.
                    state_d = mii_rx_dv ? S_DROP : S_IDLE;
                    err_inc = 1'b1;
                end else begin
                    crc_d     = crc_next;
                    phase_d   = ~phase_q;
                    lo_nib_d  = mii_rx_da;
                    nib_cnt_d = nib_cnt_q + 5'd1;
                    if (phase_q) begin
                        hdr_d      = {hdr_q[55:0], nib_byte};
                        byte_cnt_d = byte_cnt_q + 11'd1;
                    end
                    if ((nib_cnt_q == c_DST_END) && !dst_ok) begin
                        state_d = S_DROP;   // not addressed to us: silent
                    end else if (nib_cnt_q == c_HDR_END) begin
                        state_d = S_PAYLOAD;
                        src_d   = hdr_d[63:16];
                        type_d  = hdr_d[15:0];
                    end
                end
            end

            S_PAYLOAD: begin
                if (!mii_rx_dv) begin
                    // Whatever is still in the delay line is the FCS.
                    state_d = S_IDLE;
                    eof_d   = 1'b1;
                    good_d  = ~frame_bad;
                    bad_d   = frame_bad;
                    err_inc = frame_bad;
                    len_d   = len_cnt_q;
                end else begin
                    crc_d    = crc_next;
                    phase_d  = ~phase_q;
                    lo_nib_d = mii_rx_da;
                    if (mii_rx_er) begin
                        er_flag_d = 1'b1;
                    end
                    if (phase_q) begin
                        byte_cnt_d = byte_cnt_q + 11'd1;
                        if (byte_cnt_d == c_MAX_CNT) begin
                            state_d = S_DROP;
                            eof_d   = 1'b1;
                            bad_d   = 1'b1;
                            err_inc = 1'b1;
                            len_d   = len_cnt_q;
                        end else begin
                            dl_d = {dl_q[2:0], nib_byte};
                            if (dl_cnt_q == 3'd4) begin
                                vld_d     = 1'b1;
                                byte_d    = dl_q[3];
                                sof_d     = (len_cnt_q == 11'd0);
                                len_cnt_d = len_cnt_q + 11'd1;
                            end else begin
                                dl_cnt_d = dl_cnt_q + 3'd1;
                            end
                        end
                    end
                end
            end

            S_DROP: begin
                if (!mii_rx_dv) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = (err_inc && (err_q != 16'hFFFF)) ? (err_q + 16'd1) : err_q;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge mii_rx_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            pre_seen_q <= 1'b0;
            nib_cnt_q  <= 5'd0;
            phase_q    <= 1'b0;
            lo_nib_q   <= 4'h0;
            hdr_q      <= 64'h0;
            byte_cnt_q <= 11'd0;
            crc_q      <= 32'h0;
            er_flag_q  <= 1'b0;
            dl_q       <= '0;
            dl_cnt_q   <= 3'd0;
            len_cnt_q  <= 11'd0;
            sof_q      <= 1'b0;
            vld_q      <= 1'b0;
            byte_q     <= 8'h0;
            eof_q      <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            len_q      <= 11'd0;
            src_q      <= 48'h0;
            type_q     <= 16'h0;
            err_q      <= 16'h0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            pre_seen_q <= pre_seen_d;
            nib_cnt_q  <= nib_cnt_d;
            phase_q    <= phase_d;
            lo_nib_q   <= lo_nib_d;
            hdr_q      <= hdr_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            er_flag_q  <= er_flag_d;
            dl_q       <= dl_d;
            dl_cnt_q   <= dl_cnt_d;
            len_cnt_q  <= len_cnt_d;
            sof_q      <= sof_d;
            vld_q      <= vld_d;
            byte_q     <= byte_d;
            eof_q      <= eof_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            len_q      <= len_d;
            src_q      <= src_d;
            type_q     <= type_d;
            err_q      <= err_d;
        end
    end

    assign rx_sof      = sof_q;
    assign rx_byte_vld = vld_q;
    assign rx_byte     = byte_q;
    assign rx_eof      = eof_q;
    assign rx_good     = good_q;
    assign rx_bad      = bad_q;
    assign rx_len      = len_q;
    assign rx_src_mac  = src_q;
    assign rx_len_type = type_q;
    assign err_cnt     = err_q;

endmodule
`default_nettype wire
